// File: rtl/gd_multistart_ctrl.sv
// Multi-start sequencer: seeds NUM_STARTS descents from an LFSR and keeps the global minimum.
// Latency: 4 GEN cycles + core run time + 1 CAPTURE + RELEASE handshake per start, 1-cycle FINISH.
// Backpressure: one run in flight; waits on gd_done_op (bounded by TIMEOUT_CYCLES) and on its release.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, lfsr_seed              operation request (IDLE only) and LFSR seed (0 maps to 1)
//   gd_start_op, gd_[a-d]_init    launch handshake and Q8.8 start point to the descent core
//   gd_done_op, gd_converged      completion handshake and convergence flag from the core
//   gd_z_min, gd_[a-d]_at_min     per-run minimum (Q24.8) and its Q8.8 coordinates
//   best_z, best_[a-d], best_run  global minimum over all runs, its coordinates and run index
//   best_valid, conv_count        some run improved best_z / number of converged runs (saturating)
//   timeout_err                   sticky: a run was abandoned for lack of gd_done_op
//   busy, done                    operation in progress / one-cycle completion pulse
module gd_multistart_ctrl #(
    parameter int NUM_STARTS     = 8,
    parameter int RANGE_SHIFT    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] lfsr_seed,
    output logic        gd_start_op,
    output logic [15:0] gd_a_init,
    output logic [15:0] gd_b_init,
    output logic [15:0] gd_c_init,
    output logic [15:0] gd_d_init,
    input  logic        gd_done_op,
    input  logic        gd_converged,
    input  logic [31:0] gd_z_min,
    input  logic [15:0] gd_a_at_min,
    input  logic [15:0] gd_b_at_min,
    input  logic [15:0] gd_c_at_min,
    input  logic [15:0] gd_d_at_min,
    output logic [31:0] best_z,
    output logic [15:0] best_a,
    output logic [15:0] best_b,
    output logic [15:0] best_c,
    output logic [15:0] best_d,
    output logic [7:0]  best_run,
    output logic        best_valid,
    output logic [7:0]  conv_count,
    output logic        timeout_err,
    output logic        busy,
    output logic        done
);

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] Z_MAX     = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_LAUNCH,
        S_CAPTURE,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [31:0]   lfsr_q;
    logic [31:0]   lfsr_adv;
    logic [15:0]   coord;
    logic [1:0]    gen_k;
    logic [7:0]    run_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          last_run;
    logic          improve;

    // Galois right-shift step; the low half of the stepped word becomes the coordinate.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    assign lfsr_adv = lfsr_step(lfsr_q);
    assign coord    = $signed(lfsr_adv[15:0]) >>> RANGE_SHIFT;
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign last_run = ({1'b0, run_cnt} + 9'd1) == 9'(NUM_STARTS);
    // Strict compare: a tie keeps the earlier run, and Z_MAX can never win.
    assign improve  = $signed(gd_z_min) < $signed(best_z);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                if (gen_k == 2'd3) begin
                    state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (gd_done_op) begin
                    state_nxt = S_CAPTURE;
                end else if (tmo_hit) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_CAPTURE: begin
                state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                // Core must drop done_op before the next launch, or it would be seen as a stale result.
                if (!gd_done_op) begin
                    state_nxt = last_run ? S_FINISH : S_GEN;
                end
            end
            S_FINISH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gd_start_op <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            gd_start_op <= (state_nxt == S_LAUNCH) || (state_nxt == S_CAPTURE);
            done        <= (state_nxt == S_FINISH);
            if (state_q == S_IDLE && start) begin
                busy <= 1'b1;
            end else if (state_nxt == S_FINISH) begin
                busy <= 1'b0;
            end
        end
    end

    // LFSR and start-point generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q    <= 32'h1;
            gen_k     <= 2'd0;
            gd_a_init <= 16'h0;
            gd_b_init <= 16'h0;
            gd_c_init <= 16'h0;
            gd_d_init <= 16'h0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                lfsr_q <= (lfsr_seed == 32'h0) ? 32'h1 : lfsr_seed;
                gen_k  <= 2'd0;
            end
        end else if (state_q == S_GEN) begin
            lfsr_q <= lfsr_adv;
            gen_k  <= gen_k + 2'd1;
            case (gen_k)
                2'd0:    gd_a_init <= coord;
                2'd1:    gd_b_init <= coord;
                2'd2:    gd_c_init <= coord;
                default: gd_d_init <= coord;
            endcase
        end
    end

    // Run bookkeeping, timeout and global-best tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= 8'd0;
            tmo_cnt     <= '0;
            best_z      <= Z_MAX;
            best_a      <= 16'h0;
            best_b      <= 16'h0;
            best_c      <= 16'h0;
            best_d      <= 16'h0;
            best_run    <= 8'd0;
            best_valid  <= 1'b0;
            conv_count  <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        run_cnt     <= 8'd0;
                        tmo_cnt     <= '0;
                        best_z      <= Z_MAX;
                        best_a      <= 16'h0;
                        best_b      <= 16'h0;
                        best_c      <= 16'h0;
                        best_d      <= 16'h0;
                        best_run    <= 8'd0;
                        best_valid  <= 1'b0;
                        conv_count  <= 8'd0;
                        timeout_err <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    if (!gd_done_op && tmo_hit) begin
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (improve) begin
                        best_z     <= gd_z_min;
                        best_a     <= gd_a_at_min;
                        best_b     <= gd_b_at_min;
                        best_c     <= gd_c_at_min;
                        best_d     <= gd_d_at_min;
                        best_run   <= run_cnt;
                        best_valid <= 1'b1;
                    end
                    if (gd_converged && conv_count != 8'hFF) begin
                        conv_count <= conv_count + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (!gd_done_op) begin
                        run_cnt <= run_cnt + 8'd1;
                        tmo_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gd_multistart_ctrl.sv
// Directed bench for gd_multistart_ctrl with a small behavioural descent-core model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_gd_multistart_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] lfsr_seed = 32'h0;
    logic        gd_start_op;
    logic [15:0] gd_a_init, gd_b_init, gd_c_init, gd_d_init;
    logic        gd_done_op;
    logic        gd_converged;
    logic [31:0] gd_z_min;
    logic [15:0] gd_a_at_min, gd_b_at_min, gd_c_at_min, gd_d_at_min;
    logic [31:0] best_z;
    logic [15:0] best_a, best_b, best_c, best_d;
    logic [7:0]  best_run;
    logic        best_valid;
    logic [7:0]  conv_count;
    logic        timeout_err;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gd_multistart_ctrl #(
        .NUM_STARTS    (3),
        .RANGE_SHIFT   (0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .lfsr_seed   (lfsr_seed),
        .gd_start_op (gd_start_op),
        .gd_a_init   (gd_a_init),
        .gd_b_init   (gd_b_init),
        .gd_c_init   (gd_c_init),
        .gd_d_init   (gd_d_init),
        .gd_done_op  (gd_done_op),
        .gd_converged(gd_converged),
        .gd_z_min    (gd_z_min),
        .gd_a_at_min (gd_a_at_min),
        .gd_b_at_min (gd_b_at_min),
        .gd_c_at_min (gd_c_at_min),
        .gd_d_at_min (gd_d_at_min),
        .best_z      (best_z),
        .best_a      (best_a),
        .best_b      (best_b),
        .best_c      (best_c),
        .best_d      (best_d),
        .best_run    (best_run),
        .best_valid  (best_valid),
        .conv_count  (conv_count),
        .timeout_err (timeout_err),
        .busy        (busy),
        .done        (done)
    );

    // Core model: per-run result tables, done_op 3 cycles after start_op rises,
    // dropped 2 cycles after start_op falls; a hung run never raises done_op.
    logic [31:0] z_tab    [4];
    logic        conv_tab [4];
    logic        hang_tab [4];
    logic        model_clr = 1'b0;
    logic [1:0]  m_run;
    logic        m_prev;
    logic [1:0]  m_lat;
    logic [1:0]  m_fall;
    logic        m_done;

    assign gd_done_op   = m_done;
    assign gd_converged = conv_tab[m_run];
    assign gd_z_min     = z_tab[m_run];
    assign gd_a_at_min  = {6'd0, m_run, 8'h0A};
    assign gd_b_at_min  = {6'd0, m_run, 8'h0B};
    assign gd_c_at_min  = {6'd0, m_run, 8'h0C};
    assign gd_d_at_min  = {6'd0, m_run, 8'h0D};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || model_clr) begin
            m_run  <= 2'd0;
            m_prev <= 1'b0;
            m_lat  <= 2'd0;
            m_fall <= 2'd0;
            m_done <= 1'b0;
        end else begin
            m_prev <= gd_start_op;
            if (gd_start_op && !m_prev) begin
                m_lat <= 2'd3;
            end else if (gd_start_op && m_lat > 2'd1) begin
                m_lat <= m_lat - 2'd1;
            end else if (gd_start_op && m_lat == 2'd1 && !hang_tab[m_run]) begin
                m_lat  <= 2'd0;
                m_done <= 1'b1;
            end
            if (!gd_start_op && m_prev) begin
                m_fall <= 2'd2;
                m_run  <= m_run + 2'd1;
            end else if (m_fall == 2'd2) begin
                m_fall <= 2'd1;
            end else if (m_fall == 2'd1) begin
                m_fall <= 2'd0;
                m_done <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_tabs(input logic [31:0] z0, input logic [31:0] z1, input logic [31:0] z2,
                            input logic [2:0] conv, input logic [2:0] hang);
        z_tab[0] = z0;  z_tab[1] = z1;  z_tab[2] = z2;  z_tab[3] = 32'h7FFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            conv_tab[i] = conv[i];
            hang_tab[i] = hang[i];
        end
        conv_tab[3] = 1'b0;
        hang_tab[3] = 1'b0;
        model_clr = 1'b1;
        @(posedge clk);
        #1 model_clr = 1'b0;
    endtask

    // Accepts a start and returns the number of edges (accepting edge included) until gd_start_op.
    task automatic launch(input logic [31:0] seed, output int lat);
        lfsr_seed = seed;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (!gd_start_op && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    // Counts done pulses until busy falls, plus a short tail to catch extra pulses.
    task automatic wait_done(output int pulses);
        pulses = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
            if (pulses > 0 && !busy) break;
        end
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    int lat;
    int pulses;

    initial begin
        set_tabs(32'h500, 32'h200, 32'h200, 3'b101, 3'b000);
        #23;
        // Reset state
        check("rst_start_op", 32'(gd_start_op), 32'h0);
        check("rst_best_z", best_z, 32'h7FFF_FFFF);
        check("rst_best_valid", 32'(best_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_a_init", 32'(gd_a_init), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // A: seed 1, z = 0x500/0x200/0x200, converged on runs 0 and 2
        set_tabs(32'h500, 32'h200, 32'h200, 3'b101, 3'b000);
        launch(32'h1, lat);
        check("A_launch_lat", 32'(lat), 32'd5);
        check("A_busy", 32'(busy), 32'h1);
        check("A_a_init", 32'(gd_a_init), 32'h3);
        check("A_b_init", 32'(gd_b_init), 32'h2);
        check("A_c_init", 32'(gd_c_init), 32'h1);
        check("A_d_init", 32'(gd_d_init), 32'h3);
        start = 1'b1;
        lfsr_seed = 32'h1234;
        @(posedge clk);
        #1 start = 1'b0;
        check("A_init_hold", 32'(gd_a_init), 32'h3);
        wait_done(pulses);
        check("A_done_pulses", 32'(pulses), 32'd1);
        check("A_best_z", best_z, 32'h200);
        check("A_best_run", 32'(best_run), 32'd1);
        check("A_best_valid", 32'(best_valid), 32'h1);
        check("A_best_a", 32'(best_a), 32'h010A);
        check("A_best_d", 32'(best_d), 32'h010D);
        check("A_conv_count", 32'(conv_count), 32'd2);
        check("A_timeout_err", 32'(timeout_err), 32'h0);
        check("A_busy_after", 32'(busy), 32'h0);

        // B: seed 0 behaves like seed 1; no run improves on Z_MAX
        set_tabs(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3'b000, 3'b000);
        launch(32'h0, lat);
        check("B_launch_lat", 32'(lat), 32'd5);
        check("B_a_init", 32'(gd_a_init), 32'h3);
        check("B_b_init", 32'(gd_b_init), 32'h2);
        check("B_c_init", 32'(gd_c_init), 32'h1);
        check("B_d_init", 32'(gd_d_init), 32'h3);
        wait_done(pulses);
        check("B_done_pulses", 32'(pulses), 32'd1);
        check("B_best_valid", 32'(best_valid), 32'h0);
        check("B_best_z", best_z, 32'h7FFF_FFFF);
        check("B_conv_count", 32'(conv_count), 32'd0);

        // C: run 1 hangs; run 2 returns a negative minimum
        set_tabs(32'h300, 32'h10, 32'hFFFF_FF00, 3'b110, 3'b010);
        launch(32'hACE1, lat);
        wait_done(pulses);
        check("C_done_pulses", 32'(pulses), 32'd1);
        check("C_timeout_err", 32'(timeout_err), 32'h1);
        check("C_best_z", best_z, 32'hFFFF_FF00);
        check("C_best_run", 32'(best_run), 32'd2);
        check("C_best_a", 32'(best_a), 32'h020A);
        check("C_conv_count", 32'(conv_count), 32'd1);

        // D: asynchronous reset while launched, then a clean operation
        set_tabs(32'h500, 32'h200, 32'h200, 3'b101, 3'b000);
        launch(32'h1, lat);
        check("D_launch_lat", 32'(lat), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("D_rst_start_op", 32'(gd_start_op), 32'h0);
        check("D_rst_busy", 32'(busy), 32'h0);
        check("D_rst_timeout", 32'(timeout_err), 32'h0);
        check("D_rst_best_z", best_z, 32'h7FFF_FFFF);
        check("D_rst_a_init", 32'(gd_a_init), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_tabs(32'h500, 32'h200, 32'h200, 3'b101, 3'b000);
        launch(32'h1, lat);
        check("D2_launch_lat", 32'(lat), 32'd5);
        wait_done(pulses);
        check("D2_done_pulses", 32'(pulses), 32'd1);
        check("D2_best_z", best_z, 32'h200);
        check("D2_best_run", 32'(best_run), 32'd1);
        check("D2_conv_count", 32'(conv_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gd_multistart_ctrl.md
Name: gd_multistart_ctrl

Overview:
Multi-start sequencer sitting directly upstream of the 4D gradient-descent core.
- Generates NUM_STARTS pseudo-random Q8.8 starting points (a,b,c,d) from an LFSR.
- Launches one descent per point over the core's start_op/done_op handshake.
- Keeps the global best z_min and its coordinates across all runs, so the system escapes local minima that a single descent would settle in.

Parameters:
NUM_STARTS, 8, number of descent runs per operation (1..255)
RANGE_SHIFT, 4, arithmetic right shift applied to raw 16-bit LFSR words; 4 gives start points in roughly ±8.0 (Q8.8)
TIMEOUT_CYCLES, 4096, maximum cycles to wait for gd_done_op before a run is abandoned

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
start  in  1  begin operation; sampled only in IDLE
lfsr_seed  in  32  LFSR seed loaded on accepted start; 0 is replaced by 32'h1
gd_start_op  out  1  to core start_op
gd_a_init, gd_b_init, gd_c_init, gd_d_init  out  16 each  to core *_init, signed Q8.8
gd_done_op  in  1  from core done_op
gd_converged  in  1  from core converged
gd_z_min  in  32  from core z_min, signed Q24.8
gd_a_at_min, gd_b_at_min, gd_c_at_min, gd_d_at_min  in  16 each  from core, signed Q8.8
best_z  out  32  global minimum, signed Q24.8
best_a, best_b, best_c, best_d  out  16 each  coordinates at best_z
best_run  out  8  index (0-based) of run that produced best_z
best_valid  out  1  at least one run improved best_z
conv_count  out  8  number of runs that reported converged
timeout_err  out  1  sticky: at least one run timed out
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all runs finished

Behaviour:
- Reset (async, rst_n low): state IDLE; gd_start_op=0; gd_*_init=0; best_z=32'h7FFFFFFF; best_a..d=0; best_run=0; best_valid=0; conv_count=0; timeout_err=0; busy=0; done=0; lfsr=32'h1; run counter=0; timeout counter=0.
- Reset mid-operation has the same effect. gd_start_op drops asynchronously, which returns the core to IDLE through its own handshake.
- LFSR is Galois, right-shifting. One step: lsb=lfsr[0]; lfsr=(lfsr>>1) ^ (lsb ? 32'h80200003 : 0).
- FSM states: IDLE, GEN, LAUNCH, CAPTURE, RELEASE, FINISH.
- IDLE: when start=1, load lfsr (seed, or 1 if seed==0) and clear best_*, best_valid, conv_count, timeout_err and the run counter. Set busy=1 and go to GEN. start is ignored in every other state.
- GEN: 4 cycles, k=0..3. Each cycle the LFSR steps once. Coordinate k = $signed(new_lfsr[15:0]) >>> RANGE_SHIFT, in the order a,b,c,d. Then go to LAUNCH.
- LAUNCH: gd_start_op=1, registered, first asserted on the cycle after the last GEN cycle. gd_*_init stay stable while gd_start_op=1. The timeout counter increments every cycle.
  - gd_done_op=1 → CAPTURE.
  - Counter reaches TIMEOUT_CYCLES-1 with no gd_done_op → set timeout_err, skip CAPTURE, go to RELEASE.
- CAPTURE (1 cycle):
  - If $signed(gd_z_min) < $signed(best_z) (strict, so ties keep the earlier run): store gd_z_min and gd_*_at_min into best_*, set best_run=run counter and best_valid=1.
  - If gd_converged: conv_count+1, saturating at 255.
  - Then go to RELEASE.
- RELEASE: gd_start_op=0. Wait until gd_done_op=0 (the core lowers it 2 cycles after start_op falls). Then:
  - run counter+1 and timeout counter cleared;
  - if run counter+1 == NUM_STARTS → FINISH, else → GEN.
- FINISH: done=1 for exactly one cycle, busy=0, go to IDLE. best_*, conv_count and timeout_err hold until the next accepted start.
- gd_*_init hold their last values outside GEN.
- A core result of 32'h7FFFFFFF never updates best_z (strict compare). best_valid stays 0 if no run improves.

Test Plan:
- lfsr_seed=1, RANGE_SHIFT=0 → first GEN gives gd_a/b/c/d_init = 0x0003, 0x0002, 0x0001, 0x0003. gd_start_op rises 5 cycles after the start cycle.
- lfsr_seed=0 → identical init values to seed=1.
- NUM_STARTS=3, core model returns z = 0x500, 0x200, 0x200 → best_z=0x200, best_run=1, best_valid=1, one done pulse, busy low afterwards.
- Core model converged=1 on runs 0 and 2 of 3 → conv_count=2.
- TIMEOUT_CYCLES=16, model never raises done_op on run 1 → timeout_err=1, best_* from runs 0 and 2 only, done still pulses.
- rst_n low during LAUNCH → gd_start_op=0 immediately, all outputs at reset values. A new start then works normally. start pulsed while busy → ignored.
